// File: rtl/pixel_writer.sv
// Pixel-to-MCB write engine: packs 8-bit pixels into 32-bit masked word writes.
// Define PIXEL_WRITER_COALESCE_EN to merge pixels of the same word before writing.
module pixel_writer #(
   parameter int          FLUSH_TIMEOUT       = 16,
   parameter logic [13:0] GRAPHICS_MEM_PREFIX = 14'h0040,
   parameter int          SCREEN_HEIGHT       = 192
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        px_valid,
   output logic        px_ready,
   input  logic [7:0]  px_x,
   input  logic [7:0]  px_y,
   input  logic [7:0]  px_color,
   input  logic        flush,
   output logic        busy,
   output logic        error,
   output logic        mem_cmd_en,
   output logic [2:0]  mem_cmd_instr,
   output logic [5:0]  mem_cmd_bl,
   output logic [29:0] mem_cmd_byte_addr,
   input  logic        mem_cmd_full,
   output logic        mem_wr_en,
   output logic [3:0]  mem_wr_mask,
   output logic [31:0] mem_wr_data,
   input  logic        mem_wr_full,
   input  logic        mem_wr_empty,
   input  logic [6:0]  mem_wr_count,
   input  logic        mem_wr_underrun,
   input  logic        mem_wr_error
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] CMD   = 2'd3;
   localparam logic [7:0] HEIGHT8 = 8'(SCREEN_HEIGHT);

   logic [1:0]  state;
   logic [13:0] acc_word;
   logic [31:0] acc_data;
   logic [3:0]  acc_mask;

   logic [13:0] px_word;
   logic        on_screen, accept;
   logic [3:0]  byte_sel, fresh_mask;
   logic [31:0] fresh_data;

   assign mem_cmd_instr = 3'b000;
   assign mem_cmd_bl    = 6'd0;
   assign px_ready      = !reset && (state == IDLE || state == ACCUM);

   // Word index is the pixel offset {y, x} with the byte lane dropped.
   always_comb begin
      px_word    = {px_y, px_x[7:2]};
      on_screen  = px_y < HEIGHT8;
      accept     = px_valid && px_ready;
      byte_sel   = 4'b0001 << px_x[1:0];
      fresh_mask = ~byte_sel;
      fresh_data = 32'h0;
      fresh_data[{px_x[1:0], 3'b000} +: 8] = px_color;
   end

`ifdef PIXEL_WRITER_COALESCE_EN
   localparam int         TW   = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(FLUSH_TIMEOUT - 1);

   logic [TW-1:0] tcount;
   logic          pend_valid;
   logic [13:0]   pend_word;
   logic [31:0]   pend_data;
   logic [3:0]    pend_mask;
   logic [31:0]   merged_data;
   logic [3:0]    merged_mask;

   always_comb begin
      merged_data = acc_data;
      merged_data[{px_x[1:0], 3'b000} +: 8] = px_color;
      merged_mask = acc_mask & ~byte_sel;
   end

   assign busy = (state != IDLE) || pend_valid;
`else
   assign busy = (state != IDLE);
`endif

   logic unused_ok;
   assign unused_ok = ^{mem_wr_empty, mem_wr_count, flush, (FLUSH_TIMEOUT != 0)};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         acc_word          <= '0;
         acc_data          <= '0;
         acc_mask          <= 4'hF;
         mem_wr_en         <= 1'b0;
         mem_cmd_en        <= 1'b0;
         mem_wr_mask       <= 4'hF;
         mem_wr_data       <= '0;
         mem_cmd_byte_addr <= '0;
         error             <= 1'b0;
`ifdef PIXEL_WRITER_COALESCE_EN
         tcount     <= '0;
         pend_valid <= 1'b0;
         pend_word  <= '0;
         pend_data  <= '0;
         pend_mask  <= 4'hF;
`endif
      end else begin
         mem_wr_en  <= 1'b0;
         mem_cmd_en <= 1'b0;
         if (mem_wr_underrun || mem_wr_error) error <= 1'b1;

         case (state)
            IDLE: begin
               if (accept && on_screen) begin
                  acc_word <= px_word;
                  acc_data <= fresh_data;
                  acc_mask <= fresh_mask;
`ifdef PIXEL_WRITER_COALESCE_EN
                  tcount <= '0;
                  state  <= flush ? WRITE : ACCUM;
`else
                  state  <= WRITE;
`endif
               end
            end
            ACCUM: begin
`ifdef PIXEL_WRITER_COALESCE_EN
               // A pixel for another word parks in pending while this word drains.
               if (accept && on_screen && px_word != acc_word) begin
                  pend_valid <= 1'b1;
                  pend_word  <= px_word;
                  pend_data  <= fresh_data;
                  pend_mask  <= fresh_mask;
                  state      <= WRITE;
               end else if (accept && on_screen) begin
                  acc_data <= merged_data;
                  acc_mask <= merged_mask;
                  tcount   <= '0;
                  if (merged_mask == 4'b0000 || flush) state <= WRITE;
               end else if (flush || tcount == TMAX) begin
                  state <= WRITE;
               end else begin
                  tcount <= tcount + 1'b1;
               end
`else
               state <= IDLE;
`endif
            end
            WRITE: begin
               if (!mem_wr_full) begin
                  mem_wr_en   <= 1'b1;
                  mem_wr_data <= acc_data;
                  mem_wr_mask <= acc_mask;
                  state       <= CMD;
               end
            end
            default: begin
               // The command trails its data by at least one cycle, so the enables never overlap.
               if (!mem_cmd_full) begin
                  mem_cmd_en        <= 1'b1;
                  mem_cmd_byte_addr <= {GRAPHICS_MEM_PREFIX, acc_word, 2'b00};
                  state             <= IDLE;
`ifdef PIXEL_WRITER_COALESCE_EN
                  if (pend_valid) begin
                     pend_valid <= 1'b0;
                     acc_word   <= pend_word;
                     acc_data   <= pend_data;
                     acc_mask   <= pend_mask;
                     tcount     <= '0;
                     state      <= ACCUM;
                  end
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 16, meaning idle cycles after the last accepted pixel before a partial word is written.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports px_valid input 1, px_ready output 1: pixel-write handshake, transfer on px_valid && px_ready at a clk edge.
REQ-005 SHALL have ports px_x input 8, px_y input 8, px_color input 8: pixel coordinate and 8-bit colour.
REQ-006 SHALL have port flush  input  1  forces write-out of any held partial word.
REQ-007 SHALL have ports busy output 1 (state != IDLE or pending held) and error output 1 (sticky memory fault).
REQ-008 SHALL have MCB command ports mem_cmd_en out 1, mem_cmd_instr out 3, mem_cmd_bl out 6, mem_cmd_byte_addr out 30, mem_cmd_full in 1.
REQ-009 SHALL have MCB write ports mem_wr_en out 1, mem_wr_mask out 4, mem_wr_data out 32, mem_wr_full in 1, mem_wr_empty in 1, mem_wr_count in 7, mem_wr_underrun in 1, mem_wr_error in 1.

Function
REQ-010 SHALL compute pixel byte offset as {px_y, px_x}; word address {GRAPHICS_MEM_PREFIX, px_y, px_x[7:2], 2'b00}.
REQ-011 SHALL drive mem_cmd_instr = 3'b000 (write) and mem_cmd_bl = 6'd0 (one word) constantly.
REQ-012 SHALL place byte n of a word (x[1:0]=n) in mem_wr_data[8n+7:8n]; mem_wr_mask bit n = 1 means byte n NOT written.
REQ-013 SHALL accept but discard (no memory traffic) pixels with px_y >= SCREEN_HEIGHT (192).
REQ-014 SHALL implement states IDLE, ACCUM, WRITE, CMD; px_ready = 1 exactly in IDLE and ACCUM.
REQ-015 IDLE: on accept, load accumulator (word addr, data byte, clear that mask bit, others 1) -> ACCUM.
REQ-016 ACCUM: accept to same word merges byte (later write to same byte overwrites), clears mask bit, reloads timeout counter.
REQ-017 ACCUM: accept to different word stores pixel in one-entry pending register -> WRITE.
REQ-018 ACCUM -> WRITE also when mask becomes 4'b0000, flush is high, or timeout counter reaches FLUSH_TIMEOUT.
REQ-019 Accept and flush in the same cycle: pixel merged first, then flush applies.
REQ-020 WRITE: while mem_wr_full, hold; else assert mem_wr_en for exactly one cycle with accumulator data/mask -> CMD.
REQ-021 CMD: while mem_cmd_full, hold; else assert mem_cmd_en for exactly one cycle with word address -> ACCUM loading pending if held, else IDLE.
REQ-022 mem_wr_en and mem_cmd_en SHALL be registered, never high in the same cycle, and each word SHALL be pushed to the write FIFO before its command.
REQ-023 error SHALL set on any cycle mem_wr_underrun or mem_wr_error is high and clear only on reset.
REQ-024 flush in IDLE with nothing held SHALL be ignored.

Reset
REQ-025 On reset: state IDLE, px_ready 0 while reset is high then 1, mem_cmd_en 0, mem_wr_en 0, mem_wr_mask 4'hF, mem_wr_data 0, mem_cmd_byte_addr 0, busy 0, error 0.
REQ-026 Reset mid-operation SHALL discard accumulator and pending pixel; a word already pushed without its command is the MCB owner's to clear.

Configuration
REQ-027 With PIXEL_WRITER_COALESCE_EN defined, behaviour is REQ-015..REQ-019.
REQ-028 Without PIXEL_WRITER_COALESCE_EN: ACCUM is unused, every accepted on-screen pixel goes IDLE -> WRITE -> CMD -> IDLE as a single-byte masked write, FLUSH_TIMEOUT and flush ignored, pending never used.

Verification
REQ-029 Pixels (4,10,0x11),(5,10,0x22),(6,10,0x33),(7,10,0x44) back-to-back -> one mem_wr_en with data 0x44332211 mask 0000, then one mem_cmd_en addr {PREFIX,16'h0A04}.
REQ-030 Single pixel (1,0,0xAB), then 16 idle cycles -> data byte1 = 0xAB, mask 1101, addr {PREFIX,16'h0000}.
REQ-031 (0,0,0x01) then (8,0,0x02) -> first word written mask 1110, second held then written on flush, addr offset 0x0008.
REQ-032 mem_wr_full high 20 cycles during WRITE -> no mem_wr_en, px_ready 0, no mem_cmd_en until full drops.
REQ-033 Pixel at y=192 -> accepted, no mem_wr_en/mem_cmd_en; mem_wr_error pulse -> error stays 1 until reset.
